// File: rtl/mult_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mult_acc_stage                                               |
// | Description : Streaming multiply-accumulate stage. Accepts unsigned        |
// |               operand pairs over a valid/ready handshake and forms the     |
// |               full-width product a*b of each pair. ACC_LEN consecutive     |
// |               products are summed modulo 2^ACC_WIDTH. The sum is then      |
// |               presented on a valid/ready output with a sticky flag that    |
// |               records any carry out of the accumulator.                    |
// | Ports       : clk        - clock, rising-edge active                       |
// |               rst_n      - asynchronous active-low reset                   |
// |               in_valid   - operand pair on a/b is valid                    |
// |               in_ready   - stage accepts a pair this cycle (state only)    |
// |               a, b       - unsigned operands, DATA_WIDTH bits              |
// |               out_valid  - out_acc/out_ovf hold a completed result         |
// |               out_ready  - downstream takes the result this cycle          |
// |               out_acc    - accumulated sum modulo 2^ACC_WIDTH              |
// |               out_ovf    - a carry left the accumulator in this result     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mult_acc_stage #(
  parameter int unsigned DATA_WIDTH = 2,
  parameter int unsigned ACC_WIDTH  = 8,
  parameter int unsigned ACC_LEN    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_ovf
);

  localparam int unsigned PROD_W = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(ACC_LEN + 1);
  // Zero bits needed to widen the product up to the ACC_WIDTH+1 adder.
  localparam int unsigned PAD_W  = ACC_WIDTH + 1 - PROD_W;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Two-state controller: collecting products, or holding a finished result.
  localparam logic [0:0] ST_ACCUM = 1'b0;
  localparam logic [0:0] ST_DONE  = 1'b1;

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (ACC_WIDTH < PROD_W) begin : g_chk_acc_width
    $error("mult_acc_stage: ACC_WIDTH must be at least 2*DATA_WIDTH");
  end
  if (ACC_LEN < 1) begin : g_chk_acc_len
    $error("mult_acc_stage: ACC_LEN must be at least 1");
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]           state_q, state_d;
  logic [ACC_WIDTH-1:0] acc_q,   acc_d;
  logic                 ovf_q,   ovf_d;
  logic [CNT_W-1:0]     cnt_q,   cnt_d;

  // --------------------------------------------------------------------------
  // Datapath: full-width product and one-bit-wider sum so the carry out of
  // the accumulator is visible directly as the MSB.
  // --------------------------------------------------------------------------
  logic [PROD_W-1:0]    w_prod;
  logic [ACC_WIDTH:0]   w_sum;
  logic                 w_accept;
  logic                 w_emit;

  assign w_prod = {{DATA_WIDTH{1'b0}}, a} * {{DATA_WIDTH{1'b0}}, b};
  assign w_sum  = {1'b0, acc_q} + {{PAD_W{1'b0}}, w_prod};

  // Handshake qualifiers are derived from the registered state only, so
  // in_ready never depends combinationally on in_valid or out_ready.
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = (state_q == ST_DONE);
  assign w_accept  = in_valid  && in_ready;
  assign w_emit    = out_ready && out_valid;

  assign out_acc = acc_q;
  assign out_ovf = ovf_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_ACCUM: begin
        if (w_accept) begin
          acc_d = w_sum[ACC_WIDTH-1:0];
          // Sticky: once any addition wraps, the result is flagged.
          ovf_d = ovf_q | w_sum[ACC_WIDTH];
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_DONE: begin
        // Result is held untouched until the downstream takes it; the
        // accumulator is cleared so the next pair starts a fresh sum.
        if (w_emit) begin
          acc_d   = '0;
          ovf_d   = 1'b0;
          state_d = ST_ACCUM;
        end
      end

      default: begin
        state_d = ST_ACCUM;
        acc_d   = '0;
        ovf_d   = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mult_acc_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mult_acc_stage                                            |
// | Description : Self-checking bench for mult_acc_stage. Three instances:     |
// |               u0 defaults, u1 ACC_WIDTH=5, u2 ACC_LEN=1. A behavioural     |
// |               model per instance tracks the integer sum of accepted        |
// |               products and whether a result is pending; the expected       |
// |               outputs follow from that sum by plain arithmetic.            |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mult_acc_stage;

  logic       clk;
  logic [2:0] rst_n;
  logic [2:0] in_valid;
  logic [2:0] out_ready;
  logic [1:0] a_s [3];
  logic [1:0] b_s [3];
  logic       in_ready  [3];
  logic       out_valid [3];
  logic       out_ovf   [3];
  logic [7:0] acc0;
  logic [4:0] acc1;
  logic [7:0] acc2;

  int n_checks = 0;
  int n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  mult_acc_stage u0 (
    .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_s[0]), .b(b_s[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_acc(acc0), .out_ovf(out_ovf[0])
  );

  mult_acc_stage #(.ACC_WIDTH(5)) u1 (
    .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_s[1]), .b(b_s[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_acc(acc1), .out_ovf(out_ovf[1])
  );

  mult_acc_stage #(.ACC_LEN(1)) u2 (
    .clk(clk), .rst_n(rst_n[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a_s[2]), .b(b_s[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_acc(acc2), .out_ovf(out_ovf[2])
  );

  function automatic int aw_of(input int i);
    return (i == 1) ? 5 : 8;
  endfunction

  function automatic logic [31:0] acc_of(input int i);
    case (i)
      0:       return {24'd0, acc0};
      1:       return {27'd0, acc1};
      default: return {24'd0, acc2};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Behavioural model: the integer sum of products of the current result and
  // whether a result is waiting. Outputs are derived from it in the checker.
  // ---------------------------------------------------------------------------
  int e_sum  [3];
  bit e_done [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_model
    localparam int LEN = (gi == 2) ? 1 : 4;
    int m_sum  = 0;
    int m_cnt  = 0;
    bit m_done = 1'b0;

    always @(posedge clk or negedge rst_n[gi]) begin
      if (!rst_n[gi]) begin
        m_sum  <= 0;
        m_cnt  <= 0;
        m_done <= 1'b0;
      end else if (!m_done) begin
        if (in_valid[gi]) begin
          m_sum <= m_sum + int'(a_s[gi]) * int'(b_s[gi]);
          if (m_cnt + 1 == LEN) begin
            m_cnt  <= 0;
            m_done <= 1'b1;
          end else begin
            m_cnt <= m_cnt + 1;
          end
        end
      end else if (out_ready[gi]) begin
        m_done <= 1'b0;
        m_sum  <= 0;
      end
    end

    assign e_sum[gi]  = m_sum;
    assign e_done[gi] = m_done;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Compare process: every cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("u%0d.in_ready", i),  32'(in_ready[i]),  32'(!e_done[i]));
        chk($sformatf("u%0d.out_valid", i), 32'(out_valid[i]), 32'(e_done[i]));
        chk($sformatf("u%0d.out_acc", i),   acc_of(i),
            32'(e_sum[i] % (1 << aw_of(i))));
        chk($sformatf("u%0d.out_ovf", i),   32'(out_ovf[i]),
            32'(e_sum[i] >= (1 << aw_of(i))));
      end
    end
  end

  // Inputs change one time unit after the falling edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic feed(input int i, input int x, input int y);
    in_valid[i] = 1'b1;
    a_s[i]      = 2'(x);
    b_s[i]      = 2'(y);
    tick();
    in_valid[i] = 1'b0;
  endtask

  task automatic lit(input string nm, input int i, input int ir, input int ov,
                     input int acc, input int ovf);
    chk({nm, ".in_ready"},  32'(in_ready[i]),  32'(ir));
    chk({nm, ".out_valid"}, 32'(out_valid[i]), 32'(ov));
    chk({nm, ".out_acc"},   acc_of(i),         32'(acc));
    chk({nm, ".out_ovf"},   32'(out_ovf[i]),   32'(ovf));
  endtask

  initial begin
    rst_n     = 3'b000;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      a_s[i] = '0;
      b_s[i] = '0;
    end
    repeat (2) tick();
    for (int i = 0; i < 3; i++) lit($sformatf("reset_u%0d", i), i, 1, 0, 0, 0);
    rst_n = 3'b111;
    tick();

    // Back-to-back stream, out_ready high: 9+6+1+0 = 16.
    feed(0, 3, 3); feed(0, 2, 3); feed(0, 1, 1);
    chk("s1.valid_before_last", 32'(out_valid[0]), 32'd0);
    feed(0, 0, 2);
    lit("s1.result", 0, 0, 1, 16, 0);
    tick();
    lit("s1.after", 0, 1, 0, 0, 0);

    // Backpressure: 4 x 9 = 36 held while out_ready low, stray pulses ignored.
    out_ready[0] = 1'b0;
    repeat (4) feed(0, 3, 3);
    for (int k = 0; k < 5; k++) begin
      lit("s2.hold", 0, 0, 1, 36, 0);
      in_valid[0] = 1'($urandom_range(0, 1));
      a_s[0]      = 2'($urandom_range(0, 3));
      b_s[0]      = 2'($urandom_range(0, 3));
      tick();
    end
    lit("s2.hold_end", 0, 0, 1, 36, 0);
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    tick();
    lit("s2.released", 0, 1, 0, 0, 0);

    // 5-bit accumulator: 36 mod 32 = 4 with overflow, then a clean 4.
    repeat (4) feed(1, 3, 3);
    lit("s3.wrap", 1, 0, 1, 4, 1);
    tick();
    repeat (4) feed(1, 1, 1);
    lit("s3.clean", 1, 0, 1, 4, 0);
    tick();

    // Gaps between pairs: 4+3+3+1 = 11.
    feed(0, 2, 2);
    repeat (3) tick();
    feed(0, 1, 3);
    tick();
    feed(0, 3, 1);
    chk("s4.valid_before_last", 32'(out_valid[0]), 32'd0);
    feed(0, 1, 1);
    lit("s4.result", 0, 0, 1, 11, 0);
    tick();

    // Asynchronous reset mid-accumulation discards the partial sum.
    feed(0, 3, 3); feed(0, 3, 3);
    chk("s5.partial", acc_of(0), 32'd18);
    #2 rst_n[0] = 1'b0;
    #1;
    lit("s5.in_reset", 0, 1, 0, 0, 0);
    rst_n[0] = 1'b1;
    tick();
    repeat (4) feed(0, 1, 2);
    lit("s5.result", 0, 0, 1, 8, 0);
    tick();

    // ACC_LEN=1 with in_valid held: 6, bubble, 9.
    in_valid[2] = 1'b1; a_s[2] = 2'd2; b_s[2] = 2'd3;
    tick();
    lit("s6.first", 2, 0, 1, 6, 0);
    a_s[2] = 2'd3; b_s[2] = 2'd3;
    tick();
    lit("s6.bubble", 2, 1, 0, 0, 0);
    tick();
    lit("s6.second", 2, 0, 1, 9, 0);
    in_valid[2] = 1'b0;
    tick();

    // Randomized traffic with occasional asynchronous resets.
    repeat (400) begin
      for (int i = 0; i < 3; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        a_s[i]       = 2'($urandom_range(0, 3));
        b_s[i]       = 2'($urandom_range(0, 3));
        rst_n[i]     = ($urandom_range(0, 149) != 0);
      end
      tick();
    end
    rst_n     = 3'b111;
    in_valid  = 3'b000;
    out_ready = 3'b111;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
